// File: rtl/md_pkg.sv
// Shared types and encodings for the HI/LO multiply/divide issue controller.
// Holds the md_op codes, controller state, and the decoded request kinds.
package md_pkg;

  localparam int LAUNCH_TMO_DEF = 4;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_DIVU  = 2'b01;
  localparam logic [1:0] MD_MULT  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_WR
  } md_state_t;

  typedef enum logic [3:0] {
    REQ_NONE,
    REQ_MULTU,
    REQ_DIVU,
    REQ_MULT,
    REQ_MSUB,
    REQ_DIV,
    REQ_MTHI,
    REQ_MTLO,
    REQ_MFHI,
    REQ_MFLO
  } md_req_t;

  function automatic logic [1:0] reqOp(input md_req_t k);
    case (k)
      REQ_DIVU:           return MD_DIVU;
      REQ_MULT, REQ_MSUB: return MD_MULT;
      REQ_DIV:            return MD_DIV;
      default:            return MD_MULTU;
    endcase
  endfunction

  function automatic logic isStart(input md_req_t k);
    return (k == REQ_MULTU) || (k == REQ_DIVU) || (k == REQ_MULT) ||
           (k == REQ_MSUB)  || (k == REQ_DIV);
  endfunction

endpackage

// File: rtl/md_issue_ctrl_arb.sv
// Priority decode of the nine MD-class decode bits into a single request kind,
// plus detection of a multi-hot decode (more than one bit set).
module md_issue_ctrl_arb
  import md_pkg::*;
(
  input  logic    i_is_multu,
  input  logic    i_is_divu,
  input  logic    i_is_mult,
  input  logic    i_is_div,
  input  logic    i_is_msub,
  input  logic    i_is_mthi,
  input  logic    i_is_mtlo,
  input  logic    i_is_mfhi,
  input  logic    i_is_mflo,
  output md_req_t o_kind,
  output logic    o_multiHot
);

  logic [8:0] w_vec;

  assign w_vec = {i_is_multu, i_is_divu, i_is_mult, i_is_msub, i_is_div,
                  i_is_mthi, i_is_mtlo, i_is_mfhi, i_is_mflo};

  // Clearing the lowest set bit leaves something only when two or more are set.
  assign o_multiHot = |(w_vec & (w_vec - 9'd1));

  always_comb begin
    o_kind = REQ_NONE;
    if (i_is_multu)     o_kind = REQ_MULTU;
    else if (i_is_divu) o_kind = REQ_DIVU;
    else if (i_is_mult) o_kind = REQ_MULT;
    else if (i_is_msub) o_kind = REQ_MSUB;
    else if (i_is_div)  o_kind = REQ_DIV;
    else if (i_is_mthi) o_kind = REQ_MTHI;
    else if (i_is_mtlo) o_kind = REQ_MTLO;
    else if (i_is_mfhi) o_kind = REQ_MFHI;
    else if (i_is_mflo) o_kind = REQ_MFLO;
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// Pipeline-side initiator for the HI/LO multiply/divide unit: launches ops,
// tracks the busy window, stalls on HI/LO hazards and returns mfhi/mflo reads.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int LAUNCH_TMO = LAUNCH_TMO_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  input  logic              i_flush,
  input  logic              i_is_multu,
  input  logic              i_is_divu,
  input  logic              i_is_mult,
  input  logic              i_is_div,
  input  logic              i_is_msub,
  input  logic              i_is_mthi,
  input  logic              i_is_mtlo,
  input  logic              i_is_mfhi,
  input  logic              i_is_mflo,
  input  logic [DATA_W-1:0] i_rs_val,
  input  logic [DATA_W-1:0] i_rt_val,
  input  logic              i_md_busy,
  input  logic [DATA_W-1:0] i_md_hi,
  input  logic [DATA_W-1:0] i_md_lo,
  output logic              o_md_start,
  output logic              o_md_ifmsub,
  output logic              o_md_mthi,
  output logic              o_md_mtlo,
  output logic              o_md_regwrite,
  output logic [1:0]        o_md_op,
  output logic [DATA_W-1:0] o_md_in1,
  output logic [DATA_W-1:0] o_md_in2,
  output logic              o_stall,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_err
);

  localparam int CNT_W = (LAUNCH_TMO > 1) ? $clog2(LAUNCH_TMO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAUNCH_TMO - 1);

  md_state_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_start;
  logic              r_ifmsub;
  logic              r_mthi;
  logic              r_mtlo;
  logic              r_regwrite;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_in1;
  logic [DATA_W-1:0] r_in2;
  logic [DATA_W-1:0] r_rdData;
  logic              r_rdValid;
  logic              r_err;

  md_req_t w_kind;
  logic    w_multiHot;
  logic    w_mdClass;
  logic    w_accept;

  md_issue_ctrl_arb u_arb (
    .i_is_multu (i_is_multu),
    .i_is_divu  (i_is_divu),
    .i_is_mult  (i_is_mult),
    .i_is_div   (i_is_div),
    .i_is_msub  (i_is_msub),
    .i_is_mthi  (i_is_mthi),
    .i_is_mtlo  (i_is_mtlo),
    .i_is_mfhi  (i_is_mfhi),
    .i_is_mflo  (i_is_mflo),
    .o_kind     (w_kind),
    .o_multiHot (w_multiHot)
  );

  // md_busy is part of the stall so a unit still busy after reset is honoured.
  assign w_mdClass = i_req_valid & ~i_flush & (w_kind != REQ_NONE);
  assign o_stall   = w_mdClass & ((r_state != ST_IDLE) | i_md_busy);
  assign w_accept  = w_mdClass & ~o_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_start    <= 1'b0;
      r_ifmsub   <= 1'b0;
      r_mthi     <= 1'b0;
      r_mtlo     <= 1'b0;
      r_regwrite <= 1'b0;
      r_op       <= MD_MULTU;
      r_in1      <= '0;
      r_in2      <= '0;
      r_rdData   <= '0;
      r_rdValid  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_start    <= 1'b0;
      r_ifmsub   <= 1'b0;
      r_mthi     <= 1'b0;
      r_mtlo     <= 1'b0;
      r_regwrite <= 1'b0;
      r_rdValid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_multiHot) r_err <= 1'b1;
            if (isStart(w_kind)) begin
              r_start  <= 1'b1;
              r_op     <= reqOp(w_kind);
              r_ifmsub <= (w_kind == REQ_MSUB);
              r_in1    <= i_rs_val;
              r_in2    <= i_rt_val;
              r_cnt    <= '0;
              r_state  <= ST_LAUNCH;
            end else if (w_kind == REQ_MTHI || w_kind == REQ_MTLO) begin
              r_regwrite <= 1'b1;
              r_mthi     <= (w_kind == REQ_MTHI);
              r_mtlo     <= (w_kind == REQ_MTLO);
              r_in1      <= i_rs_val;
              r_state    <= ST_WR;
            end else if (w_kind == REQ_MFHI) begin
              r_rdData  <= i_md_hi;
              r_rdValid <= 1'b1;
            end else if (w_kind == REQ_MFLO) begin
              r_rdData  <= i_md_lo;
              r_rdValid <= 1'b1;
            end
          end
        end
        // A unit that never raises busy is abandoned after LAUNCH_TMO cycles.
        ST_LAUNCH: begin
          if (i_md_busy) begin
            r_cnt   <= '0;
            r_state <= ST_WAIT;
          end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (!i_md_busy) r_state <= ST_IDLE;
        end
        ST_WR: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_md_start    = r_start;
  assign o_md_ifmsub   = r_ifmsub;
  assign o_md_mthi     = r_mthi;
  assign o_md_mtlo     = r_mtlo;
  assign o_md_regwrite = r_regwrite;
  assign o_md_op       = r_op;
  assign o_md_in1      = r_in1;
  assign o_md_in2      = r_in2;
  assign o_rd_data     = r_rdData;
  assign o_rd_valid    = r_rdValid;
  assign o_err         = r_err;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a small behavioural HI/LO multiply/divide
// unit attached; each scenario task drives vectors and checks hand-computed values.
module tb_md_issue_ctrl;

  localparam int DW = 32;
  localparam int B_MULTU = 8, B_DIVU = 7, B_MULT = 6, B_DIV = 5, B_MSUB = 4;
  localparam int B_MTHI = 3, B_MTLO = 2, B_MFHI = 1, B_MFLO = 0;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          reqValid = 1'b0;
  logic          flush = 1'b0;
  logic [8:0]    reqVec = '0;
  logic [DW-1:0] rsVal = '0;
  logic [DW-1:0] rtVal = '0;

  logic          mBusy = 1'b0;
  logic          mEnable = 1'b1;
  logic [DW-1:0] mHi = '0;
  logic [DW-1:0] mLo = '0;
  logic [2:0]    mCnt = '0;
  logic [63:0]   mPend = '0;

  logic          o_md_start, o_md_ifmsub, o_md_mthi, o_md_mtlo, o_md_regwrite;
  logic [1:0]    o_md_op;
  logic [DW-1:0] o_md_in1, o_md_in2, o_rd_data;
  logic          o_stall, o_rd_valid, o_err;

  int compared = 0;
  int mismatched = 0;

  md_issue_ctrl #(.DATA_W(DW), .LAUNCH_TMO(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_req_valid   (reqValid),
    .i_flush       (flush),
    .i_is_multu    (reqVec[B_MULTU]),
    .i_is_divu     (reqVec[B_DIVU]),
    .i_is_mult     (reqVec[B_MULT]),
    .i_is_div      (reqVec[B_DIV]),
    .i_is_msub     (reqVec[B_MSUB]),
    .i_is_mthi     (reqVec[B_MTHI]),
    .i_is_mtlo     (reqVec[B_MTLO]),
    .i_is_mfhi     (reqVec[B_MFHI]),
    .i_is_mflo     (reqVec[B_MFLO]),
    .i_rs_val      (rsVal),
    .i_rt_val      (rtVal),
    .i_md_busy     (mBusy),
    .i_md_hi       (mHi),
    .i_md_lo       (mLo),
    .o_md_start    (o_md_start),
    .o_md_ifmsub   (o_md_ifmsub),
    .o_md_mthi     (o_md_mthi),
    .o_md_mtlo     (o_md_mtlo),
    .o_md_regwrite (o_md_regwrite),
    .o_md_op       (o_md_op),
    .o_md_in1      (o_md_in1),
    .o_md_in2      (o_md_in2),
    .o_stall       (o_stall),
    .o_rd_data     (o_rd_data),
    .o_rd_valid    (o_rd_valid),
    .o_err         (o_err)
  );

  always #5 clk = ~clk;

  // Behavioural MD unit: busy for three cycles after a start, then HI/LO update.
  function automatic logic [63:0] mdCompute(input logic [1:0] op, input logic ifmsub,
                                            input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] hi, input logic [DW-1:0] lo);
    logic signed [63:0] sa, sb, acc;
    logic signed [DW-1:0] q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      2'b00: return {32'd0, a} * {32'd0, b};
      2'b01: return (b == '0) ? 64'd0 : {a % b, a / b};
      2'b10: begin
        acc = sa * sb;
        if (ifmsub) acc = $signed({hi, lo}) - acc;
        return acc;
      end
      default: begin
        if (b == '0) return 64'd0;
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
    endcase
  endfunction

  always @(posedge clk) begin
    if (o_md_regwrite) begin
      if (o_md_mthi) mHi <= o_md_in1;
      if (o_md_mtlo) mLo <= o_md_in1;
    end
    if (o_md_start && mEnable) begin
      mBusy <= 1'b1;
      mCnt  <= 3'd3;
      mPend <= mdCompute(o_md_op, o_md_ifmsub, o_md_in1, o_md_in2, mHi, mLo);
    end else if (mBusy) begin
      if (mCnt == 3'd1) begin
        mBusy <= 1'b0;
        {mHi, mLo} <= mPend;
      end
      mCnt <= mCnt - 3'd1;
    end
  end

  task automatic setReq(input logic [8:0] v, input logic [DW-1:0] rs, input logic [DW-1:0] rt);
    reqValid = (v != '0);
    reqVec   = v;
    rsVal    = rs;
    rtVal    = rt;
  endtask

  task automatic applyReset();
    @(negedge clk);
    setReq(9'd0, '0, '0);
    flush = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    applyReset();
    #1;
    compared++; if ({o_md_start, o_md_ifmsub, o_md_mthi, o_md_mtlo, o_md_regwrite, o_rd_valid, o_err} !== 7'd0) begin
      mismatched++; $display("[TB] FAIL reset_strobes got=%b exp=0000000", {o_md_start, o_md_ifmsub, o_md_mthi, o_md_mtlo, o_md_regwrite, o_rd_valid, o_err}); end
    compared++; if ({o_md_op, o_md_in1, o_md_in2, o_rd_data} !== 98'd0) begin
      mismatched++; $display("[TB] FAIL reset_data got op=%h in1=%h in2=%h rd=%h exp=0", o_md_op, o_md_in1, o_md_in2, o_rd_data); end
    setReq(9'd1 << B_MFHI, '0, '0);
    #1;
    compared++; if (o_stall !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_stall got=%b exp=0", o_stall); end
    @(negedge clk);
    setReq(9'd0, '0, '0);
  endtask

  task automatic test_mult();
    int n;
    @(negedge clk);
    setReq(9'd1 << B_MULT, 32'hFFFF_FFFF, 32'h2);
    #1;
    compared++; if (o_stall !== 1'b0) begin
      mismatched++; $display("[TB] FAIL mult_accept_stall got=%b exp=0", o_stall); end
    @(negedge clk);
    compared++; if ({o_md_start, o_md_op, o_md_ifmsub} !== 4'b1100) begin
      mismatched++; $display("[TB] FAIL mult_start got start/op/ifmsub=%b exp=1100", {o_md_start, o_md_op, o_md_ifmsub}); end
    compared++; if ({o_md_in1, o_md_in2} !== {32'hFFFF_FFFF, 32'h2}) begin
      mismatched++; $display("[TB] FAIL mult_operands got %h/%h exp ffffffff/00000002", o_md_in1, o_md_in2); end
    setReq(9'd1 << B_MFLO, '0, '0);
    #1;
    compared++; if (o_stall !== 1'b1) begin
      mismatched++; $display("[TB] FAIL mult_mflo_stall got=%b exp=1", o_stall); end
    @(negedge clk);
    compared++; if (o_md_start !== 1'b0) begin
      mismatched++; $display("[TB] FAIL mult_start_pulse got=%b exp=0", o_md_start); end
    n = 0;
    while (o_stall && n < 40) begin @(negedge clk); #1; n++; end
    compared++; if (o_stall !== 1'b0) begin
      mismatched++; $display("[TB] FAIL mult_stall_release got=%b exp=0 after %0d cycles", o_stall, n); end
    @(negedge clk);
    compared++; if ({o_rd_valid, o_rd_data} !== {1'b1, 32'hFFFF_FFFE}) begin
      mismatched++; $display("[TB] FAIL mult_mflo got v=%b d=%h exp v=1 d=fffffffe", o_rd_valid, o_rd_data); end
    setReq(9'd1 << B_MFHI, '0, '0);
    @(negedge clk);
    compared++; if ({o_rd_valid, o_rd_data} !== {1'b1, 32'hFFFF_FFFF}) begin
      mismatched++; $display("[TB] FAIL mult_mfhi got v=%b d=%h exp v=1 d=ffffffff", o_rd_valid, o_rd_data); end
    setReq(9'd0, '0, '0);
    @(negedge clk);
    compared++; if (o_rd_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL mult_rdvalid_pulse got=%b exp=0", o_rd_valid); end
  endtask

  task automatic test_divu();
    int n;
    @(negedge clk);
    setReq(9'd1 << B_DIVU, 32'd7, 32'd2);
    @(negedge clk);
    compared++; if ({o_md_start, o_md_op} !== 3'b101) begin
      mismatched++; $display("[TB] FAIL divu_start got start/op=%b exp=101", {o_md_start, o_md_op}); end
    setReq(9'd1 << B_MFLO, '0, '0);
    #1;
    n = 0;
    while (o_stall && n < 40) begin @(negedge clk); #1; n++; end
    compared++; if (o_stall !== 1'b0) begin
      mismatched++; $display("[TB] FAIL divu_stall_release got=%b exp=0", o_stall); end
    @(negedge clk);
    compared++; if ({o_rd_valid, o_rd_data} !== {1'b1, 32'h3}) begin
      mismatched++; $display("[TB] FAIL divu_mflo got v=%b d=%h exp v=1 d=00000003", o_rd_valid, o_rd_data); end
    setReq(9'd1 << B_MFHI, '0, '0);
    #1;
    compared++; if (o_stall !== 1'b0) begin
      mismatched++; $display("[TB] FAIL divu_back_to_back_stall got=%b exp=0", o_stall); end
    @(negedge clk);
    compared++; if ({o_rd_valid, o_rd_data} !== {1'b1, 32'h1}) begin
      mismatched++; $display("[TB] FAIL divu_mfhi got v=%b d=%h exp v=1 d=00000001", o_rd_valid, o_rd_data); end
    setReq(9'd0, '0, '0);
  endtask

  task automatic test_mthi();
    @(negedge clk);
    setReq(9'd1 << B_MTHI, 32'h1234, 32'h0);
    @(negedge clk);
    compared++; if ({o_md_regwrite, o_md_mthi, o_md_mtlo, o_md_start, o_md_in1} !== {4'b1100, 32'h1234}) begin
      mismatched++; $display("[TB] FAIL mthi_strobes got rw/hi/lo/start=%b in1=%h exp 1100 00001234", {o_md_regwrite, o_md_mthi, o_md_mtlo, o_md_start}, o_md_in1); end
    setReq(9'd1 << B_MFHI, '0, '0);
    #1;
    compared++; if (o_stall !== 1'b1) begin
      mismatched++; $display("[TB] FAIL mthi_wr_stall got=%b exp=1", o_stall); end
    @(negedge clk);
    compared++; if ({o_stall, o_md_regwrite} !== 2'b00) begin
      mismatched++; $display("[TB] FAIL mthi_after_wr got stall/rw=%b exp=00", {o_stall, o_md_regwrite}); end
    @(negedge clk);
    compared++; if ({o_rd_valid, o_rd_data} !== {1'b1, 32'h1234}) begin
      mismatched++; $display("[TB] FAIL mthi_mfhi got v=%b d=%h exp v=1 d=00001234", o_rd_valid, o_rd_data); end
    setReq(9'd0, '0, '0);
  endtask

  task automatic test_msub();
    int n;
    @(negedge clk);
    setReq(9'd1 << B_MTHI, 32'd0, 32'd0);
    @(negedge clk);
    setReq(9'd0, '0, '0);
    @(negedge clk);
    setReq(9'd1 << B_MTLO, 32'd100, 32'd0);
    @(negedge clk);
    compared++; if ({o_md_regwrite, o_md_mthi, o_md_mtlo} !== 3'b101) begin
      mismatched++; $display("[TB] FAIL msub_mtlo_strobes got=%b exp=101", {o_md_regwrite, o_md_mthi, o_md_mtlo}); end
    setReq(9'd0, '0, '0);
    @(negedge clk);
    setReq(9'd1 << B_MSUB, 32'd3, 32'd4);
    @(negedge clk);
    compared++; if ({o_md_start, o_md_ifmsub, o_md_op} !== 4'b1110) begin
      mismatched++; $display("[TB] FAIL msub_start got start/ifmsub/op=%b exp=1110", {o_md_start, o_md_ifmsub, o_md_op}); end
    setReq(9'd1 << B_MFLO, '0, '0);
    #1;
    n = 0;
    while (o_stall && n < 40) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    compared++; if ({o_rd_valid, o_rd_data} !== {1'b1, 32'd88}) begin
      mismatched++; $display("[TB] FAIL msub_mflo got v=%b d=%h exp v=1 d=00000058", o_rd_valid, o_rd_data); end
    compared++; if (o_err !== 1'b0) begin
      mismatched++; $display("[TB] FAIL msub_err got=%b exp=0", o_err); end
    setReq(9'd0, '0, '0);
  endtask

  task automatic test_multi_hot();
    int n;
    @(negedge clk);
    setReq((9'd1 << B_MULTU) | (9'd1 << B_MFHI), 32'd5, 32'd6);
    @(negedge clk);
    compared++; if ({o_md_start, o_md_op, o_rd_valid, o_err} !== 5'b10001) begin
      mismatched++; $display("[TB] FAIL multihot_winner got start/op/rdv/err=%b exp=10001", {o_md_start, o_md_op, o_rd_valid, o_err}); end
    setReq(9'd1 << B_MFLO, '0, '0);
    #1;
    n = 0;
    while (o_stall && n < 40) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    compared++; if ({o_rd_valid, o_rd_data} !== {1'b1, 32'd30}) begin
      mismatched++; $display("[TB] FAIL multihot_mflo got v=%b d=%h exp v=1 d=0000001e", o_rd_valid, o_rd_data); end
    setReq(9'd0, '0, '0);
  endtask

  task automatic test_flush();
    int n;
    @(negedge clk);
    setReq(9'd1 << B_MULT, 32'd2, 32'd3);
    @(negedge clk);
    compared++; if (o_md_start !== 1'b1) begin
      mismatched++; $display("[TB] FAIL flush_first_start got=%b exp=1", o_md_start); end
    setReq(9'd0, '0, '0);
    n = 0;
    while (!mBusy && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    setReq(9'd1 << B_MULT, 32'd9, 32'd9);
    flush = 1'b1;
    #1;
    compared++; if (o_stall !== 1'b0) begin
      mismatched++; $display("[TB] FAIL flush_stall got=%b exp=0", o_stall); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++; if (o_md_start !== 1'b0) begin
        mismatched++; $display("[TB] FAIL flush_no_start cycle %0d got=%b exp=0", i, o_md_start); end
    end
    flush = 1'b0;
    setReq(9'd1 << B_MFLO, '0, '0);
    #1;
    n = 0;
    while (o_stall && n < 40) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    compared++; if ({o_rd_valid, o_rd_data} !== {1'b1, 32'd6}) begin
      mismatched++; $display("[TB] FAIL flush_mflo got v=%b d=%h exp v=1 d=00000006", o_rd_valid, o_rd_data); end
    setReq(9'd0, '0, '0);
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    setReq(9'd1 << B_DIVU, 32'd9, 32'd2);
    @(negedge clk);
    setReq(9'd0, '0, '0);
    n = 0;
    while (!mBusy && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    compared++; if ({o_md_op, o_md_in1, o_md_in2, o_rd_data, o_err, o_md_start} !== 100'd0) begin
      mismatched++; $display("[TB] FAIL resetmid_outputs got op=%h in1=%h in2=%h rd=%h err=%b start=%b exp=0", o_md_op, o_md_in1, o_md_in2, o_rd_data, o_err, o_md_start); end
    setReq(9'd1 << B_MFHI, '0, '0);
    #1;
    compared++; if (o_stall !== 1'b1) begin
      mismatched++; $display("[TB] FAIL resetmid_busy_stall got=%b exp=1", o_stall); end
    n = 0;
    while (o_stall && n < 40) begin @(negedge clk); #1; n++; end
    compared++; if (o_stall !== 1'b0) begin
      mismatched++; $display("[TB] FAIL resetmid_stall_release got=%b exp=0", o_stall); end
    @(negedge clk);
    compared++; if ({o_rd_valid, o_rd_data} !== {1'b1, 32'd1}) begin
      mismatched++; $display("[TB] FAIL resetmid_mfhi got v=%b d=%h exp v=1 d=00000001", o_rd_valid, o_rd_data); end
    setReq(9'd0, '0, '0);
  endtask

  task automatic test_timeout();
    mEnable = 1'b0;
    @(negedge clk);
    setReq(9'd1 << B_MULT, 32'd1, 32'd1);
    @(negedge clk);
    compared++; if (o_md_start !== 1'b1) begin
      mismatched++; $display("[TB] FAIL timeout_start got=%b exp=1", o_md_start); end
    setReq(9'd1 << B_MFHI, '0, '0);
    for (int i = 1; i <= 4; i++) begin
      #1;
      compared++; if ({o_stall, o_err} !== 2'b10) begin
        mismatched++; $display("[TB] FAIL timeout_launch cycle %0d got stall/err=%b exp=10", i, {o_stall, o_err}); end
      @(negedge clk);
    end
    #1;
    compared++; if ({o_stall, o_err} !== 2'b01) begin
      mismatched++; $display("[TB] FAIL timeout_abort got stall/err=%b exp=01", {o_stall, o_err}); end
    @(negedge clk);
    setReq(9'd0, '0, '0);
    @(negedge clk);
    compared++; if (o_err !== 1'b1) begin
      mismatched++; $display("[TB] FAIL timeout_err_sticky got=%b exp=1", o_err); end
    mEnable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu();
    test_mthi();
    test_msub();
    test_multi_hot();
    test_flush();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
